// File: rtl/syscall_console_if.sv
`default_nettype none
// ============================================================================
//  Module   : syscall_console_if
//  Purpose  : Syscall request and console byte-stream signals shared between
//             the processor controller / console sink and syscall_console.
//  Revision : 1.0  initial release
// ============================================================================
interface syscall_console_if;
    logic        syscall;
    logic [31:0] v0;
    logic [31:0] a0;
    logic        stall;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        halted;
    logic        bad_code;

    // Controller plus console sink side
    modport master (
        output syscall, v0, a0, out_ready,
        input  stall, out_data, out_valid, halted, bad_code
    );

    // Console unit side
    modport slave (
        input  syscall, v0, a0, out_ready,
        output stall, out_data, out_valid, halted, bad_code
    );
endinterface
`default_nettype wire

// File: rtl/syscall_console.sv
`default_nettype none
// ============================================================================
//  Module   : syscall_console
//  Purpose  : Services print-char, print-int and exit syscalls. Characters
//             and decimal digits go through a byte FIFO to the console sink;
//             the processor is stalled while a service is still in progress.
//  Revision : 1.0  initial release
// ============================================================================
module syscall_console #(
    parameter int FIFO_DEPTH = 8
) (
    input  logic            clk,
    input  logic            reset_n,
    syscall_console_if.slave bus
);

    localparam int             AW         = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]    c_depth    = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0]    c_cnt_one  = 1;
    localparam logic [AW-1:0]  c_ptr_one  = 1;
    localparam logic [31:0]    c_v0_int   = 32'd1;
    localparam logic [31:0]    c_v0_exit  = 32'd10;
    localparam logic [31:0]    c_v0_char  = 32'd11;
    localparam logic [7:0]     c_minus    = 8'h2D;
    localparam logic [7:0]     c_zero_chr = 8'h30;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_CHAR = 2'd1,
        S_CONV      = 2'd2
    } state_t;

    // Controller state
    state_t        r_state;
    logic          r_stall;
    logic          r_exit_pending;
    logic          r_bad_code;
    logic [7:0]    r_char;
    logic [31:0]   r_mag;
    logic [3:0]    r_pidx;
    logic [3:0]    r_digit;
    logic          r_seen_nz;
    logic          r_neg_pending;

    // Output FIFO
    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;

    logic          w_full;
    logic          w_empty;
    logic          w_accept;
    logic          w_pop;
    logic [31:0]   w_pow;
    logic          w_ge;
    logic          w_lead_zero;
    logic          w_push_req;
    logic [7:0]    w_push_data;
    logic          w_push;
    logic          w_hold;

    // Power of ten selected by the conversion index (0 -> 1, 9 -> 10^9)
    function automatic logic [31:0] pow10(input logic [3:0] idx);
        case (idx)
            4'd0:    pow10 = 32'd1;
            4'd1:    pow10 = 32'd10;
            4'd2:    pow10 = 32'd100;
            4'd3:    pow10 = 32'd1000;
            4'd4:    pow10 = 32'd10000;
            4'd5:    pow10 = 32'd100000;
            4'd6:    pow10 = 32'd1000000;
            4'd7:    pow10 = 32'd10000000;
            4'd8:    pow10 = 32'd100000000;
            default: pow10 = 32'd1000000000;
        endcase
    endfunction

    assign w_full      = (r_count == c_depth);
    assign w_empty     = (r_count == '0);
    assign w_accept    = bus.syscall && !r_stall && !r_exit_pending;
    assign w_pop       = !w_empty && bus.out_ready;
    assign w_pow       = pow10(r_pidx);
    assign w_ge        = (r_mag >= w_pow);
    // A zero digit is suppressed until a nonzero digit appears, except the
    // units digit so that a value of zero still prints "0".
    assign w_lead_zero = !r_seen_nz && (r_digit == 4'd0) && (r_pidx != 4'd0);

    // Decide which byte, if any, the controller wants to push this cycle
    always_comb begin
        w_push_req  = 1'b0;
        w_push_data = 8'h00;
        case (r_state)
            S_IDLE: begin
                if (w_accept && bus.v0 == c_v0_char) begin
                    w_push_req  = 1'b1;
                    w_push_data = bus.a0[7:0];
                end
            end
            S_WAIT_CHAR: begin
                w_push_req  = 1'b1;
                w_push_data = r_char;
            end
            S_CONV: begin
                if (r_neg_pending) begin
                    w_push_req  = 1'b1;
                    w_push_data = c_minus;
                end else if (!w_ge && !w_lead_zero) begin
                    w_push_req  = 1'b1;
                    w_push_data = c_zero_chr + {4'b0000, r_digit};
                end
            end
            default: ;
        endcase
    end

    // A full FIFO refuses the push and freezes the requesting state
    assign w_push = w_push_req && !w_full;
    assign w_hold = w_push_req && w_full;

    // Syscall controller: decode, wait-for-space and decimal conversion
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= S_IDLE;
            r_stall        <= 1'b0;
            r_exit_pending <= 1'b0;
            r_bad_code     <= 1'b0;
            r_char         <= 8'h00;
            r_mag          <= 32'd0;
            r_pidx         <= 4'd0;
            r_digit        <= 4'd0;
            r_seen_nz      <= 1'b0;
            r_neg_pending  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (bus.v0 == c_v0_char) begin
                            if (w_full) begin
                                r_char  <= bus.a0[7:0];
                                r_state <= S_WAIT_CHAR;
                                r_stall <= 1'b1;
                            end
                        end else if (bus.v0 == c_v0_int) begin
                            r_mag         <= bus.a0[31] ? (~bus.a0 + 32'd1) : bus.a0;
                            r_neg_pending <= bus.a0[31];
                            r_pidx        <= 4'd9;
                            r_digit       <= 4'd0;
                            r_seen_nz     <= 1'b0;
                            r_state       <= S_CONV;
                            r_stall       <= 1'b1;
                        end else if (bus.v0 == c_v0_exit) begin
                            r_exit_pending <= 1'b1;
                        end else begin
                            r_bad_code <= 1'b1;
                        end
                    end
                end
                S_WAIT_CHAR: begin
                    if (!w_full) begin
                        r_state <= S_IDLE;
                        r_stall <= 1'b0;
                    end
                end
                S_CONV: begin
                    if (!w_hold) begin
                        if (r_neg_pending) begin
                            r_neg_pending <= 1'b0;
                        end else if (w_ge) begin
                            r_mag   <= r_mag - w_pow;
                            r_digit <= r_digit + 4'd1;
                        end else begin
                            if (r_digit != 4'd0) begin
                                r_seen_nz <= 1'b1;
                            end
                            r_digit <= 4'd0;
                            if (r_pidx == 4'd0) begin
                                r_state <= S_IDLE;
                                r_stall <= 1'b0;
                            end else begin
                                r_pidx <= r_pidx - 4'd1;
                            end
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_stall <= 1'b0;
                end
            endcase
        end
    end

    // FIFO pointers and occupancy; reset discards every pending byte
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

    // FIFO storage; contents are only visible while the count says valid
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_push_data;
        end
    end

    assign bus.stall     = r_stall;
    assign bus.out_valid = !w_empty;
    assign bus.out_data  = w_empty ? 8'h00 : r_mem[r_rd_ptr];
    assign bus.bad_code  = r_bad_code;
    // Once exit is pending no further syscall can push, so this stays high
    assign bus.halted    = r_exit_pending && (r_state == S_IDLE) && w_empty;

endmodule
`default_nettype wire

// File: tb/tb_syscall_console.sv
`default_nettype none
// ============================================================================
//  Module   : tb_syscall_console
//  Purpose  : Self-checking bench for syscall_console: directed scenarios plus
//             randomized print syscalls against a string-level console model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_syscall_console;

    logic clk = 1'b0;
    logic reset_n;
    logic ready_level;
    logic rand_ready;
    int   checks = 0;
    int   errors = 0;

    logic [7:0] got[$];
    logic [7:0] exp[$];

    syscall_console_if bus ();

    syscall_console #(.FIFO_DEPTH(8)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    // Sink: either a fixed ready level or a random one each cycle
    always @(negedge clk) begin
        bus.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_level;
    end

    // Record every byte handed to the sink
    always @(posedge clk) begin
        if (reset_n && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            got.push_back(bus.out_data);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    task automatic timeout(input string tag);
        checks++;
        errors++;
        $error("FAIL %s: observed timeout expected completion", tag);
    endtask

    // Console model: the text a program would see printed
    task automatic model_char(input logic [31:0] a);
        exp.push_back(a[7:0]);
    endtask

    task automatic model_int(input logic [31:0] a);
        string s;
        s = $sformatf("%0d", $signed(a));
        for (int i = 0; i < s.len(); i++) exp.push_back(s[i]);
    endtask

    task automatic check_bytes(input string tag);
        int n;
        checks++;
        assert (got.size() == exp.size()) else begin
            errors++;
            $error("FAIL %s_count: observed %0d expected %0d", tag, got.size(), exp.size());
        end
        n = (got.size() < exp.size()) ? got.size() : exp.size();
        for (int i = 0; i < n; i++) chk($sformatf("%s_byte%0d", tag, i), 32'(got[i]), 32'(exp[i]));
        got.delete();
        exp.delete();
    endtask

    // Called at a negedge; waits for stall low then presents one syscall
    task automatic issue(input logic [31:0] code, input logic [31:0] arg);
        int n = 0;
        while (bus.stall !== 1'b0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) timeout("issue_wait");
        bus.syscall = 1'b1;
        bus.v0      = code;
        bus.a0      = arg;
        @(negedge clk);
        bus.syscall = 1'b0;
        bus.v0      = $urandom;
        bus.a0      = $urandom;
    endtask

    task automatic wait_drained(input string tag);
        int n = 0;
        while (!(bus.out_valid === 1'b0 && bus.stall === 1'b0) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) timeout(tag);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        reset_n      = 1'b0;
        ready_level  = 1'b1;
        rand_ready   = 1'b0;
        bus.syscall  = 1'b0;
        bus.v0       = 32'd0;
        bus.a0       = 32'd0;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_stall", 32'(bus.stall), 32'd0);
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_data", 32'(bus.out_data), 32'd0);
        chk("rst_halted", 32'(bus.halted), 32'd0);
        chk("rst_bad", 32'(bus.bad_code), 32'd0);
        reset_n = 1'b1;

        // Single character, accepted on the first edge after release
        issue(32'd11, 32'h41);
        model_char(32'h41);
        chk("char_nostall", 32'(bus.stall), 32'd0);
        wait_drained("char_drain");
        check_bytes("char");
        chk("char_empty", 32'(bus.out_valid), 32'd0);

        // Negative integer
        issue(32'd1, 32'hFFFF_FF85);
        model_int(32'hFFFF_FF85);
        chk("neg_stall", 32'(bus.stall), 32'd1);
        wait_drained("neg_drain");
        check_bytes("neg");

        // Zero and the most negative value
        issue(32'd1, 32'd0);
        model_int(32'd0);
        issue(32'd1, 32'h8000_0000);
        model_int(32'h8000_0000);
        wait_drained("edge_drain");
        check_bytes("edge");

        // Randomized prints with a randomly stalling sink
        rand_ready = 1'b1;
        for (int k = 0; k < 24; k++) begin
            logic [31:0] a;
            case ($urandom_range(0, 3))
                0:       a = 32'($urandom_range(0, 99));
                1:       a = -32'($urandom_range(1, 99));
                default: a = $urandom;
            endcase
            if ($urandom_range(0, 1) == 0) begin
                issue(32'd11, a);
                model_char(a);
            end else begin
                issue(32'd1, a);
                model_int(a);
            end
        end
        wait_drained("rand_drain");
        rand_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_bytes("rand");

        // Back-pressure: eight fill the FIFO, the ninth stalls
        ready_level = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 9; k++) begin
            issue(32'd11, 32'h30 + 32'(k));
            model_char(32'h30 + 32'(k));
        end
        chk("full_stall", 32'(bus.stall), 32'd1);
        chk("full_head", 32'(bus.out_data), 32'h30);
        @(negedge clk);
        chk("full_head_stable", 32'(bus.out_data), 32'h30);
        chk("full_stall_hold", 32'(bus.stall), 32'd1);
        ready_level = 1'b1;
        wait_drained("full_drain");
        check_bytes("full");

        // Unsupported service code sets a sticky flag and prints nothing
        issue(32'd5, 32'h1234);
        chk("bad_flag", 32'(bus.bad_code), 32'd1);
        chk("bad_nostall", 32'(bus.stall), 32'd0);
        repeat (3) @(negedge clk);
        check_bytes("bad_nobytes");
        issue(32'd11, 32'h55);
        model_char(32'h55);
        wait_drained("bad_after_drain");
        chk("bad_sticky", 32'(bus.bad_code), 32'd1);
        check_bytes("bad_after");

        // Exit waits for output to drain, then ignores further syscalls
        ready_level = 1'b0;
        @(negedge clk);
        issue(32'd1, 32'd42);
        model_int(32'd42);
        issue(32'd10, 32'd0);
        repeat (3) @(negedge clk);
        chk("exit_not_yet", 32'(bus.halted), 32'd0);
        ready_level = 1'b1;
        begin
            int n = 0;
            while (bus.halted !== 1'b1 && n < 200) begin
                @(negedge clk);
                n++;
            end
            if (n >= 200) timeout("exit_halt_wait");
        end
        chk("exit_halted", 32'(bus.halted), 32'd1);
        check_bytes("exit");
        issue(32'd11, 32'h41);
        repeat (4) @(negedge clk);
        chk("exit_ignored_valid", 32'(bus.out_valid), 32'd0);
        chk("exit_still_halted", 32'(bus.halted), 32'd1);
        check_bytes("exit_ignored");

        // Reset in the middle of a conversion drops everything
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        chk("rst2_halted", 32'(bus.halted), 32'd0);
        chk("rst2_bad", 32'(bus.bad_code), 32'd0);
        ready_level = 1'b0;
        @(negedge clk);
        issue(32'd1, 32'd999999999);
        repeat (20) @(negedge clk);
        chk("conv_busy", 32'(bus.stall), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_stall", 32'(bus.stall), 32'd0);
        chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_data", 32'(bus.out_data), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        ready_level = 1'b1;
        repeat (40) @(negedge clk);
        chk("post_rst_valid", 32'(bus.out_valid), 32'd0);
        chk("post_rst_stall", 32'(bus.stall), 32'd0);
        check_bytes("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/syscall_console.md
SYSCALL_CONSOLE -- requirements
Module: syscall_console

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8 (power of two, >=4): output character FIFO entries.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port syscall  input  1  controller syscall strobe for the current instruction.
REQ-005 SHALL have port v0  input  32  service code from register $v0.
REQ-006 SHALL have port a0  input  32  argument from register $a0.
REQ-007 SHALL have port stall  output  1  hold PC/register write while high.
REQ-008 SHALL have port out_data  output  8  ASCII byte to console sink.
REQ-009 SHALL have port out_valid  output  1  out_data valid.
REQ-010 SHALL have port out_ready  input  1  sink accepts byte.
REQ-011 SHALL have port halted  output  1  program exit complete.
REQ-012 SHALL have port bad_code  output  1  sticky: unsupported v0 seen.

Function
REQ-013 SHALL accept a syscall on a rising edge where syscall=1, stall=0, exit_pending=0; otherwise syscall is ignored.
REQ-014 v0=11 (print char): SHALL push a0[7:0] into the FIFO in the accept cycle if not full; if full, SHALL enter state WAIT_CHAR, assert stall, push when space exists, then return to IDLE.
REQ-015 v0=1 (print int): SHALL enter state CONV with magnitude M = a0 if a0[31]=0, else (~a0+1) as 32-bit unsigned (0x80000000 -> 2147483648); for negative a0 SHALL push '-' (0x2D) first.
REQ-016 CONV SHALL walk powers P = 10^9 down to 10^0; per cycle: if M>=P then M=M-P, digit++; else finalize digit, step P down, clear digit.
REQ-017 Finalized digit SHALL be pushed as 0x30+digit unless it is a leading zero (no nonzero digit yet and P>1); value 0 SHALL print "0".
REQ-018 Any push in CONV attempted while FIFO full SHALL hold FSM (no M/P/digit change) until space exists.
REQ-019 CONV SHALL return to IDLE the cycle after the P=1 digit is pushed; stall SHALL be 1 in every cycle state!=IDLE.
REQ-020 v0=10 (exit): SHALL set exit_pending; halted SHALL rise the first cycle exit_pending=1, state=IDLE, FIFO empty, and stay 1 until reset.
REQ-021 Any other v0: SHALL set bad_code=1 (sticky), no push, no stall.
REQ-022 FIFO pop SHALL occur on rising edge with out_valid=1 and out_ready=1; out_valid = FIFO not empty; out_data = head entry, stable while out_valid=1 and out_ready=0.
REQ-023 Push when full SHALL be refused (never overwrite); push and pop in the same cycle when not full/not empty SHALL both occur, count unchanged.
REQ-024 Read/write pointers SHALL wrap modulo FIFO_DEPTH; count SHALL range 0..FIFO_DEPTH.
REQ-025 Output byte order SHALL equal push order exactly.

Reset
REQ-026 reset_n=0 SHALL immediately force: state IDLE, FIFO empty, stall=0, out_valid=0, out_data=0x00, halted=0, bad_code=0, exit_pending=0, M=0, digit=0.
REQ-027 Reset asserted mid-CONV or mid-drain SHALL discard all pending bytes; no partial output after release.
REQ-028 First syscall SHALL be accepted on the first rising edge after reset_n deasserts.

Verification
REQ-029 v0=11, a0=0x41, out_ready=1 -> one byte 0x41, stall never high, FIFO empty afterwards.
REQ-030 v0=1, a0=0xFFFFFF85 (-123), out_ready=1 -> bytes 0x2D,0x31,0x32,0x33; stall high until conversion done.
REQ-031 v0=1, a0=0 then a0=0x80000000 -> "0" then "-2147483648" (11 bytes), no leading zeros.
REQ-032 out_ready=0, nine v0=11 syscalls a0=0x30..0x38 -> first 8 fill FIFO, ninth stalls; raise out_ready -> stall drops, nine bytes in order 0x30..0x38.
REQ-033 v0=1 a0=42 then v0=10 with out_ready=0 -> halted=0 until "42" drained, then halted=1; later syscalls ignored.
REQ-034 v0=5 -> bad_code=1 sticky, no output; reset_n pulse during CONV of a0=999999999 -> outputs at reset values, no bytes emitted.
